fpu_sp_divider: RTL and testbench

//  Iterative IEEE-754 single-precision divider (a / b), the inverse operation of fpu_sp_multiplier.

---
 rtl/fpu_sp_pkg.sv | 31 +++
 rtl/fpu_sp_divider_if.sv | 23 ++
 rtl/fpu_sp_classify.sv | 18 +
 rtl/fpu_sp_divider.sv | 191 +++++++++++++++++++
 tb/tb_fpu_sp_divider.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared types and constants for the single-precision FPU blocks.
package fpu_sp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  // Bit positions inside the 5-bit flags vector {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // 26 quotient bits: integer bit, 23 fraction bits, guard, round
  localparam logic [4:0] LAST_ITER = 5'd25;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_sp_divider_if.sv
// Operand/result handshake bundle for the single-precision divider.
interface fpu_sp_divider_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/fpu_sp_classify.sv
// Operand classifier; subnormals count as zero because the FPU flushes them.
module fpu_sp_classify
  import fpu_sp_pkg::*;
(
  input  logic [7:0]  exp,
  input  logic [22:0] man,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);

  assign is_zero = (exp == 8'h00);
  assign is_inf  = (exp == EXP_MAX) && (man == 23'd0);
  assign is_nan  = (exp == EXP_MAX) && (man != 23'd0);
  assign is_snan = is_nan && !man[22];

endmodule

// File: rtl/fpu_sp_divider.sv
// Iterative binary32 divider: restoring radix-2 mantissa divide, round-to-nearest-even, FTZ/DAZ.
module fpu_sp_divider
  import fpu_sp_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] CANON_NAN = QNAN
) (
  input logic             clk,
  input logic             rst,
  fpu_sp_divider_if.slave bus
);

  generate
    if (WIDTH != 32) begin : g_bad_width
      $error("fpu_sp_divider only supports WIDTH = 32");
    end
  endgenerate

  fp32_t op_a, op_b;
  assign op_a = bus.a;
  assign op_b = bus.b;

  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  fpu_sp_classify u_class_a (
    .exp(op_a.exp), .man(op_a.man),
    .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .is_snan(a_snan)
  );

  fpu_sp_classify u_class_b (
    .exp(op_b.exp), .man(op_b.man),
    .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .is_snan(b_snan)
  );

  state_t             state;
  logic               in_ready_q, out_valid_q;
  logic [31:0]        result_q;
  logic [4:0]         flags_q;
  logic [4:0]         iter;
  logic [24:0]        rem;
  logic [23:0]        div_m;
  logic [25:0]        quo;
  logic signed [9:0]  exp_q;
  logic               sign_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  logic               res_sign;
  logic [23:0]        ma, mb;
  logic               ma_lt_mb;
  logic signed [9:0]  exp_diff;

  assign res_sign = op_a.sign ^ op_b.sign;
  assign ma       = {1'b1, op_a.man};
  assign mb       = {1'b1, op_b.man};
  assign ma_lt_mb = (ma < mb);
  assign exp_diff = $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp}) + $signed(10'(BIAS));

  logic        is_special;
  logic [31:0] spec_result;
  logic [4:0]  spec_flags;

  // Decide whether the operand pair bypasses the mantissa divide, and what it returns
  always_comb begin
    is_special  = 1'b1;
    spec_result = 32'd0;
    spec_flags  = 5'd0;
    if (a_nan || b_nan) begin
      spec_result               = CANON_NAN;
      spec_flags[FLAG_INVALID]  = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result               = CANON_NAN;
      spec_flags[FLAG_INVALID]  = 1'b1;
    end else if (a_inf) begin
      spec_result = {res_sign, EXP_MAX, 23'd0};
    end else if (b_inf || a_zero) begin
      spec_result = {res_sign, 31'd0};
    end else if (b_zero) begin
      spec_result               = {res_sign, EXP_MAX, 23'd0};
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else begin
      is_special = 1'b0;
    end
  end

  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;

  assign rem_ge   = (rem >= {1'b0, div_m});
  assign rem_sub  = rem_ge ? (rem - {1'b0, div_m}) : rem;
  assign rem_next = {rem_sub[23:0], 1'b0};

  logic              guard, rnd_bit, sticky, round_up, inexact;
  logic [24:0]       mant_sum;
  logic signed [9:0] exp_rnd;
  logic [22:0]       frac_rnd;
  logic [31:0]       rnd_result;
  logic [4:0]        rnd_flags;

  // Round the quotient to nearest-even and pack it, saturating to inf or flushing to zero
  always_comb begin
    guard      = quo[1];
    rnd_bit    = quo[0];
    sticky     = |rem;
    round_up   = guard && (rnd_bit || sticky || quo[2]);
    inexact    = guard || rnd_bit || sticky;
    mant_sum   = {1'b0, quo[25:2]} + {24'd0, round_up};
    exp_rnd    = exp_q + $signed({9'd0, mant_sum[24]});
    frac_rnd   = mant_sum[24] ? 23'd0 : mant_sum[22:0];
    rnd_result = {sign_q, exp_rnd[7:0], frac_rnd};
    rnd_flags  = 5'd0;
    if (exp_rnd >= 10'sd255) begin
      rnd_result                = {sign_q, EXP_MAX, 23'd0};
      rnd_flags[FLAG_OVERFLOW]  = 1'b1;
      rnd_flags[FLAG_INEXACT]   = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      rnd_result                = {sign_q, 31'd0};
      rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      rnd_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      rnd_flags[FLAG_INEXACT]   = inexact;
    end
  end

  // Control FSM: accept, iterate one quotient bit per cycle, round, then hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      flags_q     <= 5'd0;
      iter        <= 5'd0;
      rem         <= 25'd0;
      div_m       <= 24'd0;
      quo         <= 26'd0;
      exp_q       <= 10'sd0;
      sign_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= res_sign;
            if (is_special) begin
              result_q    <= spec_result;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              rem   <= ma_lt_mb ? {ma, 1'b0} : {1'b0, ma};
              exp_q <= ma_lt_mb ? (exp_diff - 10'sd1) : exp_diff;
              div_m <= mb;
              quo   <= 26'd0;
              iter  <= 5'd0;
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem  <= rem_next;
          quo  <= {quo[24:0], rem_ge};
          iter <= iter + 5'd1;
          if (iter == LAST_ITER) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          result_q    <= rnd_result;
          flags_q     <= rnd_flags;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sp_divider.sv
// Self-checking bench for fpu_sp_divider: directed vectors plus an arithmetic reference model.
module tb_fpu_sp_divider;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fpu_sp_divider_if bus ();

  fpu_sp_divider #(
    .WIDTH(32),
    .CANON_NAN(32'h7FC00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: divides using whole-number long division and IEEE rounding rules
  function automatic logic [36:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic              s, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
    logic              g, r, st, inex;
    int                ea, eb, e;
    longint unsigned   ma, mb, num, q, rem, keep;
    logic [31:0]       res;
    logic [4:0]        flg;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    nan_a  = (ea == 255) && (a[22:0] != 0);
    nan_b  = (eb == 255) && (b[22:0] != 0);
    snan_a = nan_a && !a[22];
    snan_b = nan_b && !b[22];
    inf_a  = (ea == 255) && (a[22:0] == 0);
    inf_b  = (eb == 255) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    res    = 32'd0;
    flg    = 5'd0;
    if (nan_a || nan_b) begin
      res = 32'h7FC00000;
      flg = (snan_a || snan_b) ? 5'b10000 : 5'b00000;
    end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
      res = 32'h7FC00000;
      flg = 5'b10000;
    end else if (inf_a) begin
      res = {s, 8'hFF, 23'd0};
    end else if (inf_b || zero_a) begin
      res = {s, 31'd0};
    end else if (zero_b) begin
      res = {s, 8'hFF, 23'd0};
      flg = 5'b01000;
    end else begin
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      e  = ea - eb + 127;
      if (ma < mb) begin
        num = ma << 26;
        e   = e - 1;
      end else begin
        num = ma << 25;
      end
      q    = num / mb;
      rem  = num % mb;
      keep = q >> 2;
      g    = q[1];
      r    = q[0];
      st   = (rem != 0);
      inex = g || r || st;
      if (g && (r || st || keep[0])) keep = keep + 1;
      if (keep == 64'h1000000) begin
        keep = 64'h800000;
        e    = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        flg = 5'b00101;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        flg = 5'b00011;
      end else begin
        res = {s, e[7:0], keep[22:0]};
        flg = {4'd0, inex};
      end
    end
    return {res, flg};
  endfunction

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_flg_q[$];
  logic [36:0] model_out;

  // Record the model's answer for every accepted operand pair and retire it on handshake
  always @(posedge clk) begin
    if (rst) begin
      exp_res_q.delete();
      exp_flg_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && exp_res_q.size() > 0) begin
        void'(exp_res_q.pop_front());
        void'(exp_flg_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        model_out = model_div(bus.a, bus.b);
        exp_res_q.push_back(model_out[36:5]);
        exp_flg_q.push_back(model_out[4:0]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Every cycle a result is presented it must match the oldest outstanding model entry
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (exp_res_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL cmp_unexpected: got out_valid=1 with result %h, expected no result", bus.result);
        end else begin
          checkOutput("cmp_result", bus.result, exp_res_q[0]);
          checkOutput("cmp_flags", {27'd0, bus.flags}, {27'd0, exp_flg_q[0]});
        end
      end
    end
  endtask

  // Present operands, wait for acceptance and then for out_valid; lat counts cycles from the accept edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain_output();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want_r, input logic [4:0] want_f, input int want_lat);
    int lat;
    applyStimulus(a, b, lat);
    checkOutput({name, "_latency"}, lat, want_lat);
    checkOutput({name, "_result"}, bus.result, want_r);
    checkOutput({name, "_flags"}, {27'd0, bus.flags}, {27'd0, want_f});
    checkOutput({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    drain_output();
  endtask

  // Runaway guard so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int lat;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_result", bus.result, 32'd0);
    checkOutput("reset_flags", {27'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
    run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
    run_op("neg_6p4_by_half", 32'hC0CCCCCD, 32'h3F000000, 32'hC14CCCCD, 5'b00000, 28);
    run_op("one_by_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28);
    run_op("three_by_two", 32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000, 28);
    run_op("two_by_three", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 28);
    run_op("ten_by_three", 32'h41200000, 32'h40400000, 32'h40555555, 5'b00001, 28);
    run_op("one_by_ten",   32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 5'b00001, 28);
    run_op("max_finite",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'b00000, 28);
    run_op("min_normal",   32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000, 28);
    run_op("overflow",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28);
    run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);

    run_op("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_op("snan_a",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    run_op("qnan_a",       32'hFFC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
    run_op("inf_by_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1);
    run_op("inf_by_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1);
    run_op("inf_by_zero",  32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1);
    run_op("neg2_by_inf",  32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 1);
    run_op("zero_by_five", 32'h00000000, 32'h40A00000, 32'h00000000, 5'b00000, 1);
    run_op("subn_by_one",  32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1);
    run_op("one_by_negsubn", 32'h3F800000, 32'h80400000, 32'hFF800000, 5'b01000, 1);

    // Backpressure: result held steady while in_valid pulses are ignored
    applyStimulus(32'h3F800000, 32'h40400000, lat);
    checkOutput("bp_latency", lat, 28);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = !i[0];
      bus.a        = 32'h3F800000;
      bus.b        = 32'h00000000;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("bp_result", bus.result, 32'h3EAAAAAB);
      checkOutput("bp_flags", {27'd0, bus.flags}, 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain_output();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_no_accept", {31'd0, bus.out_valid}, 32'd0);
    end

    // Reset part-way through the mantissa divide
    @(negedge clk);
    bus.a        = 32'h3F800000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
